unet_pvm_mul_arbiter: RTL
=========================

Name: unet_pvm_mul_arbiter

Overview:
- Shares one pipelined 18-bit signed x 8-bit unsigned multiplier among NUM_REQ requesters inside unet_pvm_top, e.g. convolution lanes that each need a weight x activation product.
- Grants round-robin with valid/ready handshakes, tags each operation and routes the product to a 1-deep per-requester result register.
- Aggregate throughput is up to one product per cycle.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- A_W, 18, width of signed operand a.
- B_W, 8, width of unsigned operand b.
- P_W, 26, product width; must equal A_W+B_W.
- MUL_STAGES, 2, register stages inside the multiplier (0..3).

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- arb_en  in  1  enables new grants.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester grant, one-hot or zero.
- req_a  in  NUM_REQ*A_W  packed signed operands; slice i belongs to requester i.
- req_b  in  NUM_REQ*B_W  packed unsigned operands.
- rsp_valid  out  NUM_REQ  per-requester result valid.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_data  out  NUM_REQ*P_W  packed signed products.
- idle  out  1  high when nothing is outstanding.

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_data=0, idle=1.
  - Round-robin pointer=0, all outstanding flags=0, all pipeline valids=0.
- Outstanding flag out[i]:
  - Set on grant to requester i.
  - Cleared on the rsp_valid[i]&&rsp_ready[i] handshake.
  - Each requester has at most one operation in flight or held.
- Eligibility: elig[i] = req_valid[i] && !out[i] && arb_en.
- Grant selection:
  - Combinational; the first eligible index searching from pointer upward, mod NUM_REQ.
  - req_ready = one-hot of the winner, or zero if no requester is eligible.
  - A handshake is req_valid[i]&&req_ready[i].
- Pointer update:
  - After a grant to i, pointer <= (i+1) mod NUM_REQ.
  - Holds when there is no grant.
- Operation issue:
  - On a grant, operands and tag i enter the multiplier in the same cycle.
  - Product = signed(a) * signed({1'b0,b}), full P_W bits, no truncation or saturation.
- Latency:
  - Grant at edge T yields rsp_valid[i]=1 from edge T+MUL_STAGES+1.
  - MUL_STAGES=0 means the product is captured directly into the result register at T+1.
- Result register i:
  - Loaded with the product when the pipeline exit carries tag i.
  - rsp_valid[i] holds, with rsp_data stable, until rsp_ready[i].
  - rsp_data slice i keeps its last value after the handshake.
- Backpressure never stalls the pipeline. Because of the outstanding flag, the exiting tag's register is always free.
- Re-issue timing:
  - A requester whose response is accepted at edge T is eligible again from cycle T+1. There is no same-cycle reissue.
  - Per-requester rate is therefore one op per MUL_STAGES+2 cycles.
- arb_en=0: no new grants; in-flight operations complete and deliver normally. The pointer holds.
- idle = ~|out.
- Reset asserted mid-operation: in-flight and held results are discarded, all outputs return to reset values, and no response is produced after reset.
- req_valid deasserted without a handshake is legal and has no effect.

Decomposition:
- Package unet_pvm_mul_pkg holds:
  - A_W/B_W/P_W defaults.
  - Tag width function clog2(NUM_REQ).
  - Pipeline entry struct {valid, tag, a, b / partial product}.
- One sub-module, unet_pvm_mul_pipe:
  - MUL_STAGES-deep registered signed x unsigned multiplier.
  - Carries valid+tag alongside the data.
  - Asynchronous active-low reset on valid bits only.
- The arbiter, outstanding flags and result registers stay in the top.

Test Plan:
- Single op: requester 2, a=-131072, b=255, MUL_STAGES=2 -> req_ready[2] is high in the same cycle, rsp_valid[2] rises 3 cycles later, rsp_data[2] = -33423360.
- All four requesters valid continuously, rsp_ready=1 -> grants go 0,1,2,3,0,... and each requester is granted again no earlier than 4 cycles after its previous grant.
- Requester 1 holds rsp_ready[1]=0 for 10 cycles -> no further grant to 1 and rsp_data[1] is stable. Others keep being served. Releasing rsp_ready lets requester 1 be granted the cycle after its handshake.
- Toggle arb_en=0 with 3 ops in flight -> all 3 responses arrive, no new req_ready, and idle=1 once they are accepted.
- Assert ap_rst_n=0 with 2 ops in flight and 1 result held -> all rsp_valid=0, idle=1, pointer=0, and no stray rsp_valid after reset release.
- Boundary products a=131071, b=255 -> 33423105; a=0, b=0 -> 0. Sweep MUL_STAGES=0 and 3, checking latency of 1 and 4 cycles respectively.

Source files
------------

// File: rtl/unet_pvm_mul_pkg.sv
// Shared widths, tag sizing and pipeline control word for the PVM multiplier arbiter.
package unet_pvm_mul_pkg;

  localparam int unsigned A_W_DEF   = 18;
  localparam int unsigned B_W_DEF   = 8;
  localparam int unsigned P_W_DEF   = A_W_DEF + B_W_DEF;
  // Wide enough for the largest supported requester count (8).
  localparam int unsigned TAG_MAX_W = 3;

  function automatic int unsigned tag_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Control word that travels with each product through the multiplier stages.
  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
  } pipe_ctl_t;

endpackage

// File: rtl/unet_pvm_mul_pipe.sv
// MUL_STAGES-deep signed x unsigned multiplier; valid and tag ride alongside the product.
module unet_pvm_mul_pipe
  import unet_pvm_mul_pkg::*;
#(
  parameter int unsigned A_W        = A_W_DEF,
  parameter int unsigned B_W        = B_W_DEF,
  parameter int unsigned P_W        = P_W_DEF,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  input  logic [TAG_MAX_W-1:0]  in_tag_i,
  input  logic signed [A_W-1:0] in_a_i,
  input  logic [B_W-1:0]        in_b_i,
  output logic                  out_valid_o,
  output logic [TAG_MAX_W-1:0]  out_tag_o,
  output logic signed [P_W-1:0] out_prod_o
);

  pipe_ctl_t             ctl_in;
  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;
  logic signed [P_W-1:0] prod_in;

  // b is unsigned: zero-extend before the signed multiply.
  assign a_ext   = P_W'(in_a_i);
  assign b_ext   = P_W'({1'b0, in_b_i});
  assign prod_in = a_ext * b_ext;
  assign ctl_in  = '{valid: in_valid_i, tag: in_tag_i};

  if (MUL_STAGES == 0) begin : g_comb
    assign out_valid_o = ctl_in.valid;
    assign out_tag_o   = ctl_in.tag;
    assign out_prod_o  = prod_in;
  end else begin : g_reg
    pipe_ctl_t             ctl_q  [MUL_STAGES];
    logic signed [P_W-1:0] prod_q [MUL_STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned s = 0; s < MUL_STAGES; s++) begin
          ctl_q[s] <= '0;
        end
      end else begin
        ctl_q[0] <= ctl_in;
        for (int unsigned s = 1; s < MUL_STAGES; s++) begin
          ctl_q[s] <= ctl_q[s-1];
        end
      end
    end

    // Datapath carries no reset; it is only consumed when the matching valid is set.
    always_ff @(posedge clk_i) begin
      prod_q[0] <= prod_in;
      for (int unsigned s = 1; s < MUL_STAGES; s++) begin
        prod_q[s] <= prod_q[s-1];
      end
    end

    assign out_valid_o = ctl_q[MUL_STAGES-1].valid;
    assign out_tag_o   = ctl_q[MUL_STAGES-1].tag;
    assign out_prod_o  = prod_q[MUL_STAGES-1];
  end

endmodule

// File: rtl/unet_pvm_mul_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NUM_REQ requesters, with a
// 1-deep result register per requester.
module unet_pvm_mul_arbiter
  import unet_pvm_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned A_W        = A_W_DEF,
  parameter int unsigned B_W        = B_W_DEF,
  parameter int unsigned P_W        = P_W_DEF,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   arb_en,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [NUM_REQ*P_W-1:0] rsp_data,
  output logic                   idle
);

  localparam int unsigned PTR_W = tag_w(NUM_REQ);

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W:0]        cand_sum;
  logic                  win_vld;
  logic                  armed_q;
  logic [NUM_REQ-1:0]    out_q, out_d;
  logic [NUM_REQ-1:0]    elig, grant;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0]    rsp_hs, exit_hit;
  logic [P_W-1:0]        rsp_data_q [NUM_REQ];
  logic signed [A_W-1:0] iss_a;
  logic [B_W-1:0]        iss_b;
  logic                  pipe_valid;
  logic [TAG_MAX_W-1:0]  pipe_tag;
  logic signed [P_W-1:0] pipe_prod;

  assign rsp_hs = rsp_valid_q & rsp_ready;
  // armed_q keeps grants off while reset is asserted, whatever req_valid does.
  assign elig   = req_valid & ~out_q & {NUM_REQ{arb_en & armed_q}};

  // First eligible index at or above the pointer, wrapping at NUM_REQ.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand_sum = '0;
    grant    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand_sum >= (PTR_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
      end
      if (!win_vld && elig[cand_sum[PTR_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand_sum[PTR_W-1:0];
      end
    end
    if (win_vld) begin
      grant[win_idx] = 1'b1;
    end
  end

  assign req_ready = grant;

  always_comb begin
    ptr_d = ptr_q;
    if (win_vld) begin
      ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // A grant never targets a set flag and a handshake never targets a clear one.
  assign out_d = (out_q | grant) & ~rsp_hs;

  always_comb begin
    iss_a = '0;
    iss_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        iss_a = req_a[i*A_W +: A_W];
        iss_b = req_b[i*B_W +: B_W];
      end
    end
  end

  unet_pvm_mul_pipe #(
    .A_W        (A_W),
    .B_W        (B_W),
    .P_W        (P_W),
    .MUL_STAGES (MUL_STAGES)
  ) u_pipe (
    .clk_i       (ap_clk),
    .rst_ni      (ap_rst_n),
    .in_valid_i  (win_vld),
    .in_tag_i    (TAG_MAX_W'(win_idx)),
    .in_a_i      (iss_a),
    .in_b_i      (iss_b),
    .out_valid_o (pipe_valid),
    .out_tag_o   (pipe_tag),
    .out_prod_o  (pipe_prod)
  );

  always_comb begin
    exit_hit = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      exit_hit[i] = pipe_valid && (pipe_tag == TAG_MAX_W'(i));
    end
  end

  assign rsp_valid_d = (rsp_valid_q & ~rsp_hs) | exit_hit;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_q       <= '0;
      armed_q     <= 1'b0;
      out_q       <= '0;
      rsp_valid_q <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        rsp_data_q[i] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      armed_q     <= 1'b1;
      out_q       <= out_d;
      rsp_valid_q <= rsp_valid_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (exit_hit[i]) begin
          rsp_data_q[i] <= pipe_prod;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign rsp_data[i*P_W +: P_W] = rsp_data_q[i];
  end

  assign rsp_valid = rsp_valid_q;
  assign idle      = ~|out_q;

  // The outstanding flag guarantees the exiting tag's result register is empty.
  assert property (@(posedge ap_clk) disable iff (!ap_rst_n) (exit_hit & rsp_valid_q) == '0);
  assert property (@(posedge ap_clk) disable iff (!ap_rst_n) $onehot0(req_ready));

endmodule
